sd_dma_ctrl: RTL and testbench

SD_DMA_CTRL -- requirements
Module: sd_dma_ctrl

---
 rtl/sd_dma_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_sd_dma_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dma_ctrl.sv
// Copies one 512-byte SD sector (128 words) from the sdcard memory map into the Cache RAM.
// CPU programs SECTOR/DEST, starts via CTRL and observes STATUS or the irq pulse.
module sd_dma_ctrl #(
    parameter logic [15:0] SDC_BASE     = 16'h3000,
    parameter logic [15:0] SDC_ADDR     = 16'h3200,
    parameter logic [15:0] SDC_READ     = 16'h3204,
    parameter logic [15:0] SDC_READY    = 16'h3220,
    parameter logic [23:0] POLL_TIMEOUT = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [1:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic [15:0] sd_a,
    output logic [31:0] sd_d,
    output logic        sd_we,
    input  logic [31:0] sd_spo,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic        ram_grant,
    output logic        irq
);

    localparam logic [1:0] RegSector = 2'd0;
    localparam logic [1:0] RegDest   = 2'd1;
    localparam logic [1:0] RegCtrl   = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    typedef enum logic [3:0] {
        StIdle,
        StSetAddr,
        StIssue,
        StSettle,
        StPoll,
        StFetch,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] sector_q;
    logic [31:0] dest_q;
    logic [31:0] ram_wdata_q;
    logic        busy_q, done_q, error_q;
    logic [6:0]  idx_q;
    logic [23:0] poll_cnt_q;
    logic [1:0]  cnt_q;
    logic [31:0] rd_mux;

    logic start;
    logic poll_expired;
    logic write_done;
    logic last_word;

    assign start        = cpu_we && (cpu_addr == RegCtrl) && cpu_wdata[0] && (state_q == StIdle);
    assign poll_expired = ({1'b0, poll_cnt_q} + 25'd1) >= {1'b0, POLL_TIMEOUT};
    assign write_done   = (state_q == StWrite) && ram_grant;
    assign last_word    = (idx_q == 7'd127);
    assign ram_wdata    = ram_wdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StSetAddr;
            StSetAddr: state_d = StIssue;
            StIssue:   state_d = StSettle;
            StSettle:  if (cnt_q == 2'd3) state_d = StPoll;
            StPoll: begin
                // Odd poll cycles see the data for the address driven one cycle earlier.
                if (cnt_q[0] && sd_spo[0]) begin
                    state_d = StFetch;
                end else if (poll_expired) begin
                    state_d = StErr;
                end
            end
            StFetch:   if (cnt_q[0]) state_d = StWrite;
            StWrite:   if (ram_grant) state_d = last_word ? StDone : StFetch;
            StDone:    state_d = StIdle;
            StErr:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        sd_a     = SDC_READY;
        sd_d     = 32'd0;
        sd_we    = 1'b0;
        ram_we   = 1'b0;
        ram_addr = 12'd0;
        irq      = 1'b0;
        case (state_q)
            StSetAddr: begin
                sd_a  = SDC_ADDR;
                sd_d  = sector_q;
                sd_we = 1'b1;
            end
            StIssue: begin
                sd_a  = SDC_READ;
                sd_d  = 32'd1;
                sd_we = 1'b1;
            end
            StFetch: sd_a = SDC_BASE + {7'd0, idx_q, 2'b00};
            StWrite: begin
                ram_we   = 1'b1;
                ram_addr = dest_q[11:0] + {5'd0, idx_q};
            end
            StDone, StErr: irq = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 2'd0;
            poll_cnt_q  <= 24'd0;
            idx_q       <= 7'd0;
            ram_wdata_q <= 32'd0;
        end else begin
            cnt_q      <= (state_d != state_q) ? 2'd0 : cnt_q + 2'd1;
            poll_cnt_q <= (state_q == StPoll) ? poll_cnt_q + 24'd1 : 24'd0;
            if (start || (state_q == StPoll && state_d == StFetch)) begin
                idx_q <= 7'd0;
            end else if (write_done && !last_word) begin
                idx_q <= idx_q + 7'd1;
            end
            if (state_q == StFetch && cnt_q[0]) begin
                ram_wdata_q <= sd_spo;
            end
        end
    end

    // Status bits are only touched by start (idle) or DONE/ERR (busy), so they never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sector_q <= 32'd0;
            dest_q   <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            if (cpu_we && state_q == StIdle) begin
                if (cpu_addr == RegSector) sector_q <= cpu_wdata;
                if (cpu_addr == RegDest)   dest_q   <= cpu_wdata;
            end
            if (start) begin
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else if (state_q == StDone) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else if (state_q == StErr) begin
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (cpu_addr)
            RegSector: rd_mux = sector_q;
            RegDest:   rd_mux = dest_q;
            RegStatus: rd_mux = {29'd0, error_q, done_q, busy_q};
            default:   rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata  <= 32'd0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_re;
            if (cpu_re) cpu_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sd_dma_ctrl.sv
// Directed bench for sd_dma_ctrl: register vector table plus transfer, timeout, stall/wrap,
// busy-protection and mid-transfer reset sequences against a small sdcard/RAM model.
module tb_sd_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_we, cpu_re;
    logic [1:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [15:0] sd_a;
    logic [31:0] sd_d;
    logic        sd_we;
    logic [31:0] sd_spo = 32'd0;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_grant = 1'b1;
    logic        irq;

    always #5 clk = ~clk;

    sd_dma_ctrl #(.POLL_TIMEOUT(24'd100)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .sd_a      (sd_a),
        .sd_d      (sd_d),
        .sd_we     (sd_we),
        .sd_spo    (sd_spo),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_grant (ram_grant),
        .irq       (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // sdcard model: one register stage, so data shows up the cycle after the address.
    logic [15:0] a_lat = 16'h3220;
    logic        we_lat = 1'b0;
    logic        rdy_armed = 1'b0;
    int          rdy_cnt = 0;
    logic        ready_en = 1'b1;
    logic        stall_mode = 1'b0;
    int          gcnt = 0;
    int          cyc = 0;

    function automatic logic [31:0] sd_read(input logic [15:0] a);
        if (a == 16'h3220) return {31'd0, rdy_armed && (rdy_cnt >= 50)};
        if (a >= 16'h3000 && a < 16'h3200) return 32'hA500 + 32'((a - 16'h3000) >> 2);
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        a_lat  <= sd_a;
        we_lat <= sd_we;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we_lat && a_lat == 16'h3204) begin
            rdy_cnt   <= 0;
            rdy_armed <= ready_en;
        end else if (rdy_cnt < 100000) begin
            rdy_cnt <= rdy_cnt + 1;
        end
        sd_spo <= sd_read(a_lat);
        if (!stall_mode) begin
            ram_grant <= 1'b1;
            gcnt      <= 0;
        end else if (gcnt == 2) begin
            gcnt      <= 0;
            ram_grant <= ~ram_grant;
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    // Monitor: logs sd writes, completed RAM writes, irq pulses and held-write stability.
    logic [47:0] ev[$];
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    int          irq_cnt = 0, irq_cyc = 0, issue_cyc = 0;
    int          stall_seen = 0, stall_viol = 0;
    logic        prev_hold = 1'b0;
    logic [11:0] prev_addr = 12'd0;
    logic [31:0] prev_data = 32'd0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold <= 1'b0;
        end else begin
            if (sd_we) ev.push_back({sd_a, sd_d});
            if (sd_we && sd_a == 16'h3204) issue_cyc <= cyc;
            if (ram_we && ram_grant) begin
                wa.push_back(ram_addr);
                wd.push_back(ram_wdata);
            end
            if (irq) begin
                irq_cnt <= irq_cnt + 1;
                irq_cyc <= cyc;
            end
            if (prev_hold) begin
                stall_seen <= stall_seen + 1;
                if (!ram_we || ram_addr != prev_addr || ram_wdata != prev_data)
                    stall_viol <= stall_viol + 1;
            end
            prev_hold <= ram_we && !ram_grant;
            prev_addr <= ram_addr;
            prev_data <= ram_wdata;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns the registered read result one cycle later.
    task automatic reg_op(input logic we, input logic re, input logic [1:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic rv);
        cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_we = 1'b0; cpu_re = 1'b0;
        rd = cpu_rdata;
        rv = cpu_rvalid;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        rv;
        reg_op(1'b1, 1'b0, a, d, rd, rv);
    endtask

    task automatic read_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        rv;
        reg_op(1'b0, 1'b1, a, 32'd0, rd, rv);
        check({nm, " rvalid"}, 32'(rv), 32'd1);
        check(nm, rd, exp);
    endtask

    task automatic wait_irq(input string nm, input int target, input int bound);
        logic reached = 1'b0;
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            if (irq_cnt >= target) begin
                reached = 1'b1;
                break;
            end
        end
        #1;
        check({nm, " irq within bound"}, 32'(reached), 32'd1);
    endtask

    task automatic check_writes(input string nm, input int b, input logic [11:0] base,
                                input int n_exp);
        int bad = 0;
        logic [11:0] ea;
        check({nm, " ram write count"}, wa.size() - b, n_exp);
        for (int k = 0; k < n_exp && b + k < wa.size(); k++) begin
            ea = base + 12'(k);
            if (wa[b+k] != ea || wd[b+k] != 32'hA500 + 32'(k)) bad++;
        end
        check({nm, " ram write seq errors"}, bad, 0);
    endtask

    task automatic check_ev(input string nm, input int b, input logic [31:0] sector);
        logic [47:0] e0, e1;
        e0 = (ev.size() > b) ? ev[b] : '1;
        e1 = (ev.size() > b + 1) ? ev[b+1] : '1;
        check({nm, " sd_we count"}, ev.size() - b, 2);
        check({nm, " set-addr a"}, 32'(e0[47:32]), 32'h3200);
        check({nm, " set-addr d"}, e0[31:0], sector);
        check({nm, " issue a"}, 32'(e1[47:32]), 32'h3204);
        check({nm, " issue d"}, e1[31:0], 32'd1);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " sd_we"}, 32'(sd_we), 32'd0);
        check({nm, " ram_we"}, 32'(ram_we), 32'd0);
        check({nm, " irq"}, 32'(irq), 32'd0);
        check({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        check({nm, " sd_a"}, 32'(sd_a), 32'h3220);
        check({nm, " sd_d"}, sd_d, 32'd0);
        check({nm, " ram_addr"}, 32'(ram_addr), 32'd0);
        check({nm, " ram_wdata"}, ram_wdata, 32'd0);
        check({nm, " cpu_rdata"}, cpu_rdata, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int wb, eb, ib, sb, vb;
        logic [31:0] rd;
        logic        rv;

        reset_n = 1'b0;
        cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 2'd0; cpu_wdata = 32'd0;

        vecs[0]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 32'h400,      32'h0};
        vecs[5]  = '{1'b0, 1'b1, 2'd0, 32'h0,        32'h400};
        vecs[6]  = '{1'b1, 1'b0, 2'd1, 32'hABCDE123, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'hABCDE123};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 32'h100,      32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'h0,        32'h100};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 32'h2,        32'h0};
        vecs[11] = '{1'b0, 1'b1, 2'd3, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 1'b1, 2'd2, 32'h0,        32'h0};

        step(2);
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1);

        for (int i = 0; i < 13; i++) begin
            reg_op(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rd, rv);
            check($sformatf("vec%0d rvalid", i), 32'(rv), 32'(vecs[i].re));
            if (vecs[i].re) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end

        // Basic transfer
        wb = wa.size(); eb = ev.size(); ib = irq_cnt;
        write_reg(2'd2, 32'd1);
        read_check("basic busy", 2'd3, 32'd1);
        wait_irq("basic", ib + 1, 3000);
        step(20);
        check("basic irq count", irq_cnt - ib, 1);
        check_ev("basic", eb, 32'h400);
        check_writes("basic", wb, 12'h100, 128);
        read_check("basic status", 2'd3, 32'd2);

        // Timeout: ready never set
        ready_en = 1'b0;
        wb = wa.size(); ib = irq_cnt;
        write_reg(2'd2, 32'd1);
        wait_irq("timeout", ib + 1, 1000);
        step(5);
        check("timeout irq count", irq_cnt - ib, 1);
        check("timeout ram writes", wa.size() - wb, 0);
        check("timeout duration in range",
              32'((irq_cyc - issue_cyc >= 100) && (irq_cyc - issue_cyc <= 110)), 32'd1);
        read_check("timeout status", 2'd3, 32'd4);
        ready_en = 1'b1;

        // Stall and wrap
        stall_mode = 1'b1;
        write_reg(2'd1, 32'hFF0);
        wb = wa.size(); ib = irq_cnt; sb = stall_seen; vb = stall_viol;
        write_reg(2'd2, 32'd1);
        wait_irq("stall", ib + 1, 6000);
        step(10);
        check_writes("stall", wb, 12'hFF0, 128);
        check("stall cycles observed", 32'(stall_seen > sb), 32'd1);
        check("stall hold violations", stall_viol - vb, 0);
        check("stall irq count", irq_cnt - ib, 1);
        stall_mode = 1'b0;

        // Busy protection
        write_reg(2'd1, 32'h100);
        wb = wa.size(); eb = ev.size(); ib = irq_cnt;
        write_reg(2'd2, 32'd1);
        for (int c = 0; c < 2000 && wa.size() - wb < 10; c++) step(1);
        write_reg(2'd0, 32'h777);
        write_reg(2'd1, 32'h222);
        write_reg(2'd2, 32'd1);
        read_check("busy sector kept", 2'd0, 32'h400);
        read_check("busy dest kept", 2'd1, 32'h100);
        wait_irq("busy", ib + 1, 3000);
        step(500);
        check("busy irq count", irq_cnt - ib, 1);
        check_ev("busy", eb, 32'h400);
        check_writes("busy", wb, 12'h100, 128);
        read_check("busy status", 2'd3, 32'd2);

        // Reset mid-transfer at i=60, then start on the first edge after release
        wb = wa.size(); ib = irq_cnt;
        write_reg(2'd2, 32'd1);
        for (int c = 0; c < 2000 && wa.size() - wb < 60; c++) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        step(3);
        check("midreset writes stopped", wa.size() - wb, 60);
        check("midreset ram_we", 32'(ram_we), 32'd0);
        wb = wa.size(); eb = ev.size(); ib = irq_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        write_reg(2'd2, 32'd1);
        read_check("post-reset busy", 2'd3, 32'd1);
        wait_irq("post-reset", ib + 1, 3000);
        step(20);
        check("post-reset irq count", irq_cnt - ib, 1);
        check_ev("post-reset", eb, 32'd0);
        check_writes("post-reset", wb, 12'h000, 128);
        read_check("post-reset status", 2'd3, 32'd2);
        read_check("post-reset sector", 2'd0, 32'd0);
        read_check("post-reset dest", 2'd1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
